reg_status_file: RTL and testbench

- Architectural register file plus per-register rename tag (RoB dependency) table for the out-of-order core.
- Sits between the dispatcher, which queries source operands and claims rd, and the RoB, which retires results.
- Successor of the single-commit RF: width, register count and RoB depth are parametrised.
- Adds a second in-order commit port and same-cycle commit-to-query bypass on both commit ports.

---
 rtl/reg_status_file.sv | 148 ++++++++++++++
 tb/tb_reg_status_file.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_status_file.sv
// reg_status_file
//   Architectural register file plus per-register rename tag table for the
//   out-of-order core. The dispatcher queries two source operands (combinational,
//   zero latency) and claims a destination; the RoB retires up to two results per
//   cycle in order (commit0 older than commit1).
//
// Optional feature (macro RF_BUSY_MASK_EN): adds output busy_mask_out carrying the
//   registered busy bit of every register.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global enable), flush_in
//   commit{0,1}_en/_rd/_tag/_data : retiring entries
//   rs{1,2}_valid/_idx            : operand queries
//   qj_/qk_busy, qj_/qk_tag, vj/vk: query results
//   alloc_en/_rd/_tag             : destination claim
//   busy_mask_out                 : (RF_BUSY_MASK_EN only) registered busy bits

module reg_status_file #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_NUM   = 32,
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 commit0_en,
  input  logic [REG_IDX_W-1:0] commit0_rd,
  input  logic [ROB_WIDTH-1:0] commit0_tag,
  input  logic [XLEN-1:0]      commit0_data,
  input  logic                 commit1_en,
  input  logic [REG_IDX_W-1:0] commit1_rd,
  input  logic [ROB_WIDTH-1:0] commit1_tag,
  input  logic [XLEN-1:0]      commit1_data,
  input  logic                 rs1_valid,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic                 rs2_valid,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic                 qj_busy,
  output logic [ROB_WIDTH-1:0] qj_tag,
  output logic [XLEN-1:0]      vj,
  output logic                 qk_busy,
  output logic [ROB_WIDTH-1:0] qk_tag,
  output logic [XLEN-1:0]      vk,
  input  logic                 alloc_en,
  input  logic [REG_IDX_W-1:0] alloc_rd,
  input  logic [ROB_WIDTH-1:0] alloc_tag
`ifdef RF_BUSY_MASK_EN
  ,
  output logic [REG_NUM-1:0]   busy_mask_out
`endif
);

  typedef struct packed {
    logic                 busy;
    logic [ROB_WIDTH-1:0] tag;
    logic [XLEN-1:0]      val;
  } query_t;

  logic [XLEN-1:0]      regs_q [REG_NUM];
  logic [XLEN-1:0]      regs_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q, busy_d;
  logic [ROB_WIDTH-1:0] tag_q  [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_d  [REG_NUM];

  // Next state. Register 0 is never written so it keeps its reset value of 0.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;

    if (commit0_en && commit0_rd != '0) begin
      regs_d[commit0_rd] = commit0_data;
      // Only the latest producer may clear busy (WAW: an older tag leaves it set).
      if (tag_q[commit0_rd] == commit0_tag) busy_d[commit0_rd] = 1'b0;
    end
    // commit1 is younger, so its write lands last when both target one register.
    if (commit1_en && commit1_rd != '0) begin
      regs_d[commit1_rd] = commit1_data;
      if (tag_q[commit1_rd] == commit1_tag) busy_d[commit1_rd] = 1'b0;
    end

    if (flush_in) begin
      busy_d = '0;
    end else if (alloc_en && alloc_rd != '0) begin
      // Allocation wins over a same-cycle busy clear.
      busy_d[alloc_rd] = 1'b1;
      tag_d[alloc_rd]  = alloc_tag;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
    end else if (rdy_in) begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  function automatic query_t lookup(input logic vld, input logic [REG_IDX_W-1:0] idx);
    query_t q;
    q = '0;
    if (!vld || idx == '0) begin
      q = '0;
    end else if (flush_in || !busy_q[idx]) begin
      // Value is ready: forward any same-cycle write, youngest first.
      q.val = regs_q[idx];
      if (commit1_en && commit1_rd == idx) begin
        q.val = commit1_data;
      end else if (commit0_en && commit0_rd == idx) begin
        q.val = commit0_data;
      end
    end else if (commit0_en && commit0_rd == idx && commit0_tag == tag_q[idx]) begin
      q.val = commit0_data;
    end else if (commit1_en && commit1_rd == idx && commit1_tag == tag_q[idx]) begin
      q.val = commit1_data;
    end else begin
      q.busy = 1'b1;
      q.tag  = tag_q[idx];
    end
    return q;
  endfunction

  query_t q1, q2;

  always_comb begin
    q1      = lookup(rs1_valid, rs1_idx);
    q2      = lookup(rs2_valid, rs2_idx);
    qj_busy = q1.busy;
    qj_tag  = q1.tag;
    vj      = q1.val;
    qk_busy = q2.busy;
    qk_tag  = q2.tag;
    vk      = q2.val;
  end

`ifdef RF_BUSY_MASK_EN
  assign busy_mask_out = busy_q;
`endif

endmodule

// File: tb/tb_reg_status_file.sv
module tb_reg_status_file;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        commit0_en, commit1_en, rs1_valid, rs2_valid, alloc_en;
  logic [4:0]  commit0_rd, commit1_rd, rs1_idx, rs2_idx, alloc_rd;
  logic [2:0]  commit0_tag, commit1_tag, alloc_tag, qj_tag, qk_tag;
  logic [31:0] commit0_data, commit1_data, vj, vk;
  logic        qj_busy, qk_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  reg_status_file dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .flush_in    (flush_in),
    .commit0_en  (commit0_en),
    .commit0_rd  (commit0_rd),
    .commit0_tag (commit0_tag),
    .commit0_data(commit0_data),
    .commit1_en  (commit1_en),
    .commit1_rd  (commit1_rd),
    .commit1_tag (commit1_tag),
    .commit1_data(commit1_data),
    .rs1_valid   (rs1_valid),
    .rs1_idx     (rs1_idx),
    .rs2_valid   (rs2_valid),
    .rs2_idx     (rs2_idx),
    .qj_busy     (qj_busy),
    .qj_tag      (qj_tag),
    .vj          (vj),
    .qk_busy     (qk_busy),
    .qk_tag      (qk_tag),
    .vk          (vk),
    .alloc_en    (alloc_en),
    .alloc_rd    (alloc_rd),
    .alloc_tag   (alloc_tag)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic clr();
    flush_in = 0;
    commit0_en = 0; commit0_rd = 0; commit0_tag = 0; commit0_data = 0;
    commit1_en = 0; commit1_rd = 0; commit1_tag = 0; commit1_data = 0;
    rs1_valid = 0; rs1_idx = 0; rs2_valid = 0; rs2_idx = 0;
    alloc_en = 0; alloc_rd = 0; alloc_tag = 0;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, checks 1 unit later.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic q1(input logic [4:0] r);
    rs1_valid = 1; rs1_idx = r;
  endtask

  task automatic q2(input logic [4:0] r);
    rs2_valid = 1; rs2_idx = r;
  endtask

  task automatic c0(input logic [4:0] rd, input logic [2:0] tg, input logic [31:0] d);
    commit0_en = 1; commit0_rd = rd; commit0_tag = tg; commit0_data = d;
  endtask

  task automatic c1(input logic [4:0] rd, input logic [2:0] tg, input logic [31:0] d);
    commit1_en = 1; commit1_rd = rd; commit1_tag = tg; commit1_data = d;
  endtask

  task automatic al(input logic [4:0] rd, input logic [2:0] tg);
    alloc_en = 1; alloc_rd = rd; alloc_tag = tg;
  endtask

  initial begin
    clr();
    rst_in = 1; rdy_in = 0;
    tick();
    rst_in = 0;
    #1;
    chk("rst_qj_busy", 32'(qj_busy), 0);
    chk("rst_qj_tag", 32'(qj_tag), 0);
    chk("rst_vj", vj, 0);
    chk("rst_qk_busy", 32'(qk_busy), 0);
    chk("rst_vk", vk, 0);
    rdy_in = 1;

    // Query r5 and r0 after reset.
    q1(5); q2(0); #1;
    chk("q5_busy", 32'(qj_busy), 0);
    chk("q5_val", vj, 0);
    chk("q0_busy", 32'(qk_busy), 0);
    chk("q0_val", vk, 0);

    // Alloc r3 tag 2, then query it.
    clr(); al(3, 2); tick();
    clr(); q1(3); #1;
    chk("r3_busy", 32'(qj_busy), 1);
    chk("r3_tag", 32'(qj_tag), 2);
    chk("r3_val_busy", vj, 0);
    // Invalid query of a busy register reads as idle zero.
    rs1_valid = 0; #1;
    chk("r3_invalid_busy", 32'(qj_busy), 0);
    chk("r3_invalid_val", vj, 0);
    rs1_valid = 1;
    // Same-cycle commit0 bypass.
    c0(3, 2, 32'hDEAD); #1;
    chk("r3_byp_busy", 32'(qj_busy), 0);
    chk("r3_byp_tag", 32'(qj_tag), 0);
    chk("r3_byp_val", vj, 32'hDEAD);
    tick();
    clr(); q1(3); #1;
    chk("r3_after_busy", 32'(qj_busy), 0);
    chk("r3_after_val", vj, 32'hDEAD);

    // WAW on r4: tag 1 then tag 5.
    clr(); al(4, 1); tick();
    clr(); al(4, 5); tick();
    clr(); c0(4, 1, 7); q1(4); #1;
    chk("r4_oldcommit_busy", 32'(qj_busy), 1);
    chk("r4_oldcommit_tag", 32'(qj_tag), 5);
    tick();
    clr(); q1(4); #1;
    chk("r4_still_busy", 32'(qj_busy), 1);
    chk("r4_still_tag", 32'(qj_tag), 5);
    // Bypass through commit1.
    c1(4, 5, 9); #1;
    chk("r4_byp1_busy", 32'(qj_busy), 0);
    chk("r4_byp1_val", vj, 9);
    tick();
    clr(); q1(4); #1;
    chk("r4_final_busy", 32'(qj_busy), 0);
    chk("r4_final_val", vj, 9);

    // Dual commit to r6: commit1 wins, also on the forward path.
    clr(); c0(6, 0, 1); c1(6, 0, 2); q1(6); #1;
    chk("r6_fwd_val", vj, 2);
    tick();
    clr(); q1(6); #1;
    chk("r6_dual_val", vj, 2);
    // Commit plus alloc to r6 in one cycle: allocation wins.
    c0(6, 0, 32'h11); al(6, 3); tick();
    clr(); q1(6); #1;
    chk("r6_alloc_busy", 32'(qj_busy), 1);
    chk("r6_alloc_tag", 32'(qj_tag), 3);

    // Flush with pending r7/r8, commit to r7 and alloc r9 in the same cycle.
    clr(); al(7, 4); tick();
    clr(); al(8, 6); tick();
    clr(); flush_in = 1; c0(7, 7, 32'h55); al(9, 1); q1(7); q2(8); #1;
    chk("flush_q7_busy", 32'(qj_busy), 0);
    chk("flush_q7_val", vj, 32'h55);
    chk("flush_q8_busy", 32'(qk_busy), 0);
    chk("flush_q8_val", vk, 0);
    tick();
    clr(); q1(7); q2(9); #1;
    chk("post_r7_busy", 32'(qj_busy), 0);
    chk("post_r7_val", vj, 32'h55);
    chk("post_r9_busy", 32'(qk_busy), 0);
    q1(8); q2(6); #1;
    chk("post_r8_busy", 32'(qj_busy), 0);
    chk("post_r6_busy", 32'(qk_busy), 0);
    chk("post_r6_val", vk, 32'h11);

    // rdy_in low: commit and alloc have no effect.
    clr(); rdy_in = 0; c0(10, 0, 32'h77); al(11, 2); tick();
    clr(); rdy_in = 1; q1(10); q2(11); #1;
    chk("hold_r10_val", vj, 0);
    chk("hold_r11_busy", 32'(qk_busy), 0);

    // Writes to r0 via commit and alloc.
    clr(); c0(0, 0, 32'h99); c1(0, 0, 32'h98); al(0, 3); q1(0); #1;
    chk("r0_same_busy", 32'(qj_busy), 0);
    chk("r0_same_val", vj, 0);
    tick();
    clr(); q1(0); q2(0); #1;
    chk("r0_busy", 32'(qj_busy), 0);
    chk("r0_val", vj, 0);
    chk("r0_tag", 32'(qk_tag), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
